// File: rtl/imem_responder.sv
// Instruction memory responder: a preloadable word RAM behind a req/gnt fetch port.
// Responses come back in order, a fixed LATENCY cycles after the grant edge.
module imem_responder #(
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_wdata_i
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]        mem_q [DEPTH_WORDS];
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] err_q;
    logic [31:0]        data_q [LATENCY];

    logic          accept;
    logic          fetch_ok;
    logic          load_ok;
    logic [AW-1:0] fetch_idx;
    logic [AW-1:0] load_idx;

    // Any address bit above the word index set means the address is past the end.
    assign fetch_ok  = (instr_addr_i[1:0] == 2'b00) && (instr_addr_i[31:AW+2] == '0);
    assign load_ok   = (load_addr_i[1:0] == 2'b00) && (load_addr_i[31:AW+2] == '0);
    assign fetch_idx = instr_addr_i[AW+1:2];
    assign load_idx  = load_addr_i[AW+1:2];

    // The count is only checked against its registered value, so a response
    // leaving this cycle never frees a slot for a grant in the same cycle.
    assign instr_gnt_o = rstn_i && instr_req_i && !load_we_i
                         && (cnt_q < CW'(MAX_OUTSTANDING));
    assign accept      = instr_req_i && instr_gnt_o;

    always_comb begin
        cnt_d = cnt_q;
        case ({accept, vld_q[LATENCY-1]})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0]  <= accept;
            err_q[0]  <= accept && !fetch_ok;
            data_q[0] <= (accept && fetch_ok) ? mem_q[fetch_idx] : 32'h0;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                err_q[i]  <= err_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    // Storage survives reset; the word is captured into the pipeline at the
    // grant edge, so a later load cannot change a response already in flight.
    always_ff @(posedge clk_i) begin
        if (load_we_i && load_ok) begin
            mem_q[load_idx] <= load_wdata_i;
        end
    end

    assign instr_rvalid_o = vld_q[LATENCY-1];
    assign instr_err_o    = vld_q[LATENCY-1] && err_q[LATENCY-1];
    assign instr_rdata_o  = vld_q[LATENCY-1] ? data_q[LATENCY-1] : 32'h0;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances (LATENCY 1 and 4) share one stimulus
// stream and are checked against a scheduled-response reference model.
module tb_imem_responder;

    localparam int DEPTH = 16;
    localparam int MAXO  = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [31:0] laddr;
    logic [31:0] wdata;
    logic [1:0]  gnt, rv, err;
    logic [31:0] rdata [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .MAX_OUTSTANDING(MAXO)) u_a (
        .clk_i(clk), .rstn_i(rstn), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt[0]), .instr_rvalid_o(rv[0]), .instr_rdata_o(rdata[0]),
        .instr_err_o(err[0]), .load_we_i(we), .load_addr_i(laddr), .load_wdata_i(wdata));

    imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4), .MAX_OUTSTANDING(MAXO)) u_b (
        .clk_i(clk), .rstn_i(rstn), .instr_req_i(req), .instr_addr_i(addr),
        .instr_gnt_o(gnt[1]), .instr_rvalid_o(rv[1]), .instr_rdata_o(rdata[1]),
        .instr_err_o(err[1]), .load_we_i(we), .load_addr_i(laddr), .load_wdata_i(wdata));

    // Reference model: responses are scheduled by due cycle, keyed cycle*2+instance.
    int          lat [2] = '{1, 4};
    int          cnt [2];
    int          cyc = 0;
    logic [32:0] sched [int];
    logic [31:0] mm [DEPTH];
    logic        exp_g [2];
    logic        exp_v [2];

    task automatic chk(string nm, int inst, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc %0d: got %h expected %h", nm, inst, cyc, act, exp);
        end
    endtask

    function automatic logic addr_ok(logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < 32'(4 * DEPTH));
    endfunction

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            logic [32:0] e;
            exp_g[i] = rstn && req && !we && (cnt[i] < MAXO);
            exp_v[i] = rstn && sched.exists(cyc * 2 + i);
            e        = exp_v[i] ? sched[cyc * 2 + i] : 33'h0;
            chk("gnt", i, 32'(gnt[i]), 32'(exp_g[i]));
            chk("rvalid", i, 32'(rv[i]), 32'(exp_v[i]));
            chk("rdata", i, rdata[i], e[31:0]);
            chk("err", i, 32'(err[i]), 32'(e[32]));
        end
    endtask

    task automatic adv();
        @(posedge clk);
        if (!rstn) begin
            sched.delete();
            cnt = '{0, 0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (exp_g[i])
                    sched[(cyc + lat[i]) * 2 + i] = addr_ok(addr) ? {1'b0, mm[addr[5:2]]} : {1'b1, 32'h0};
                if (exp_v[i])
                    sched.delete(cyc * 2 + i);
                cnt[i] = cnt[i] + int'(exp_g[i]) - int'(exp_v[i]);
            end
        end
        if (we && addr_ok(laddr))
            mm[laddr[5:2]] = wdata;
        cyc++;
        #1;
    endtask

    task automatic cycle();
        step();
        adv();
    endtask

    task automatic idle(int n);
        req = 1'b0; we = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int r;
        a = 32'($urandom_range(0, 19)) << 2;
        r = int'($urandom_range(0, 15));
        if (r == 0) a = a | 32'($urandom_range(1, 3));
        else if (r == 1) a = a | 32'h8000_0000;
        return a;
    endfunction

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [31:0] laddr;
        logic [31:0] wdata;
        logic        e_gnt;
        logic        e_rv;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    function automatic vec_t v(logic rq, logic [31:0] a, logic w, logic [31:0] la,
                               logic [31:0] wd, logic eg, logic ev, logic [31:0] ed, logic ee);
        vec_t t;
        t.req = rq; t.addr = a; t.we = w; t.laddr = la; t.wdata = wd;
        t.e_gnt = eg; t.e_rv = ev; t.e_rdata = ed; t.e_err = ee;
        return t;
    endfunction

    vec_t tbl [15];
    logic b_gnt_exp [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        // Directed sequence on the LATENCY=1 instance; expectations are for inst 0.
        tbl[0]  = v(1'b1, 32'h0,  1'b1, 32'h0,  32'h0000_0013, 1'b0, 1'b0, 32'h0, 1'b0);
        tbl[1]  = v(1'b0, 32'h0,  1'b1, 32'h4,  32'h0010_0093, 1'b0, 1'b0, 32'h0, 1'b0);
        tbl[2]  = v(1'b1, 32'h0,  1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h0, 1'b0);
        tbl[3]  = v(1'b1, 32'h4,  1'b0, 32'h0,  32'h0,         1'b1, 1'b1, 32'h0000_0013, 1'b0);
        tbl[4]  = v(1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 32'h0010_0093, 1'b0);
        tbl[5]  = v(1'b1, 32'h2,  1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h0, 1'b0);
        tbl[6]  = v(1'b1, 32'h40, 1'b0, 32'h0,  32'h0,         1'b1, 1'b1, 32'h0, 1'b1);
        tbl[7]  = v(1'b1, 32'h8,  1'b0, 32'h0,  32'h0,         1'b1, 1'b1, 32'h0, 1'b1);
        tbl[8]  = v(1'b0, 32'h0,  1'b1, 32'h8,  32'hDEAD_BEEF, 1'b0, 1'b1, 32'hA000_0002, 1'b0);
        tbl[9]  = v(1'b1, 32'h8,  1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h0, 1'b0);
        tbl[10] = v(1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        tbl[11] = v(1'b0, 32'h0,  1'b1, 32'h5,  32'h5555_5555, 1'b0, 1'b0, 32'h0, 1'b0);
        tbl[12] = v(1'b0, 32'h0,  1'b1, 32'h44, 32'h6666_6666, 1'b0, 1'b0, 32'h0, 1'b0);
        tbl[13] = v(1'b1, 32'h4,  1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h0, 1'b0);
        tbl[14] = v(1'b0, 32'h0,  1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 32'h0010_0093, 1'b0);

        cnt = '{0, 0};
        rstn = 1'b0; req = 1'b0; addr = '0; we = 1'b0; laddr = '0; wdata = '0;
        for (int k = 0; k < 3; k++) cycle();
        @(posedge clk); #1;
        rstn = 1'b1;

        for (int k = 0; k < DEPTH; k++) begin
            we = 1'b1; laddr = 32'(k * 4); wdata = 32'hA000_0000 | 32'(k);
            cycle();
        end

        for (int k = 0; k < 15; k++) begin
            req = tbl[k].req; addr = tbl[k].addr; we = tbl[k].we;
            laddr = tbl[k].laddr; wdata = tbl[k].wdata;
            step();
            chk("tbl_gnt", k, 32'(gnt[0]), 32'(tbl[k].e_gnt));
            chk("tbl_rvalid", k, 32'(rv[0]), 32'(tbl[k].e_rv));
            chk("tbl_rdata", k, rdata[0], tbl[k].e_rdata);
            chk("tbl_err", k, 32'(err[0]), 32'(tbl[k].e_err));
            adv();
        end
        idle(6);

        // Request held high on the LATENCY=4 instance: two grants, then stall until a slot frees.
        req = 1'b1; addr = 32'h0; we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("hold_gnt", k, 32'(gnt[1]), 32'(b_gnt_exp[k]));
            adv();
        end
        idle(8);

        // Reset with two requests in flight: nothing may come out afterwards.
        req = 1'b1; addr = 32'h4;
        cycle();
        cycle();
        rstn = 1'b0; req = 1'b0;
        cycle();
        cycle();
        rstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("post_rst_rv_a", k, 32'(rv[0]), 32'h0);
            chk("post_rst_rv_b", k, 32'(rv[1]), 32'h0);
            adv();
        end
        req = 1'b1; addr = 32'h0;
        step();
        chk("post_rst_gnt", 0, 32'(gnt[0]), 32'h1);
        adv();
        req = 1'b0;
        step();
        chk("post_rst_word", 0, rdata[0], 32'h0000_0013);
        adv();
        idle(6);

        for (int n = 0; n < 600; n++) begin
            req   = ($urandom_range(0, 9) < 7);
            addr  = rand_addr();
            we    = ($urandom_range(0, 7) == 0);
            laddr = rand_addr();
            wdata = $urandom;
            cycle();
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
